truth_table_checker: RTL and testbench

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

---
 rtl/truth_table_checker.sv | 135 +++++++++++++
 tb/tb_truth_table_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// Sweeps every input vector of an N_IN-input circuit, compares its response against a
// reference truth table and reports mismatch count, first failing vector and pass/fail.
module truth_table_checker #(
  parameter int unsigned N_IN     = 3,
  parameter int unsigned RESP_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [(1<<N_IN)-1:0]  tt_ref,
  output logic [N_IN-1:0]       vec_out,
  output logic                  vec_valid,
  input  logic                  resp_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_IN:0]         err_count,
  output logic                  fail_seen,
  output logic [N_IN-1:0]       first_fail
);

  localparam int unsigned NVec = 1 << N_IN;

  typedef enum logic [1:0] {StIdle, StDrive, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   idx_q;
  logic [2:0]        drain_q;
  logic [NVec-1:0]   tt_q;
  logic [N_IN:0]     err_q, err_d;
  logic              fail_q, pass_q, done_q;
  logic [N_IN-1:0]   first_q;
  logic              last_vec, drain_end;
  logic              cmp_valid, mismatch;
  logic [N_IN-1:0]   cmp_idx;

  assign last_vec  = (idx_q == N_IN'(NVec - 1));
  assign drain_end = (drain_q == 3'(RESP_LAT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StDrive;
      StDrive: if (last_vec) state_d = (RESP_LAT == 0) ? StDone : StDrain;
      StDrain: if (drain_end) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != StIdle);
    vec_valid = (state_q == StDrive);
    vec_out   = vec_valid ? idx_q : '0;
  end

  // Delay line aligning each stimulus index with the response it produces
  if (RESP_LAT == 0) begin : g_no_delay
    assign cmp_valid = vec_valid;
    assign cmp_idx   = vec_out;
  end else begin : g_delay
    logic [RESP_LAT-1:0] dv_q;
    logic [N_IN-1:0]     di_q [RESP_LAT];

    always_ff @(posedge clk) begin
      if (rst) begin
        dv_q <= '0;
        for (int k = 0; k < int'(RESP_LAT); k++) di_q[k] <= '0;
      end else begin
        dv_q[0] <= vec_valid;
        di_q[0] <= vec_out;
        for (int k = 1; k < int'(RESP_LAT); k++) begin
          dv_q[k] <= dv_q[k-1];
          di_q[k] <= di_q[k-1];
        end
      end
    end

    assign cmp_valid = dv_q[RESP_LAT-1];
    assign cmp_idx   = di_q[RESP_LAT-1];
  end

  assign mismatch = cmp_valid && (resp_in != tt_q[cmp_idx]);
  assign err_d    = err_q + {{N_IN{1'b0}}, mismatch};

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      drain_q <= '0;
      tt_q    <= '0;
      err_q   <= '0;
      fail_q  <= 1'b0;
      first_q <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      idx_q   <= (state_q == StDrive) ? idx_q + 1'b1 : '0;
      drain_q <= (state_q == StDrain) ? drain_q + 1'b1 : '0;
      done_q  <= 1'b0;
      if (state_q == StIdle && start) begin
        tt_q    <= tt_ref;
        err_q   <= '0;
        fail_q  <= 1'b0;
        first_q <= '0;
        pass_q  <= 1'b0;
      end else begin
        err_q <= err_d;
        if (mismatch && !fail_q) begin
          fail_q  <= 1'b1;
          first_q <= cmp_idx;
        end
        // done/pass are registered so they reflect any compare made in the DONE cycle
        if (state_q == StDone) begin
          done_q <= 1'b1;
          pass_q <= (err_d == '0);
        end
      end
    end
  end

  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_seen  = fail_q;
  assign first_fail = first_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Runs three checker instances (response latency 0, 1, 3) against a modelled circuit
// under test, using table-driven and random truth tables plus reset/abort sequences.
module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tt_ref = '0;
  logic [7:0] circ_tt = '0;

  logic [2:0] vec [3];
  logic       vvalid [3];
  logic       resp [3];
  logic       busy [3];
  logic       done [3];
  logic       pass [3];
  logic [3:0] errc [3];
  logic       fail [3];
  logic [2:0] ff [3];

  int checks = 0;
  int failures = 0;
  int lat_of [3] = '{0, 1, 3};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 0 : (g == 1) ? 1 : 3;

    if (Lat == 0) begin : g_comb
      assign resp[g] = circ_tt[vec[g]];
    end else begin : g_pipe
      logic [Lat-1:0] pipe = '0;
      always @(posedge clk) begin
        pipe[0] <= circ_tt[vec[g]];
        for (int k = 1; k < Lat; k++) pipe[k] <= pipe[k-1];
      end
      assign resp[g] = pipe[Lat-1];
    end

    truth_table_checker #(.N_IN(3), .RESP_LAT(Lat)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .tt_ref     (tt_ref),
      .vec_out    (vec[g]),
      .vec_valid  (vvalid[g]),
      .resp_in    (resp[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .pass       (pass[g]),
      .err_count  (errc[g]),
      .fail_seen  (fail[g]),
      .first_fail (ff[g])
    );
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_vec%0d", nm, g), int'(vec[g]), 0);
      chk($sformatf("%s_valid%0d", nm, g), int'(vvalid[g]), 0);
      chk($sformatf("%s_busy%0d", nm, g), int'(busy[g]), 0);
      chk($sformatf("%s_done%0d", nm, g), int'(done[g]), 0);
      chk($sformatf("%s_pass%0d", nm, g), int'(pass[g]), 0);
      chk($sformatf("%s_err%0d", nm, g), int'(errc[g]), 0);
      chk($sformatf("%s_fail%0d", nm, g), int'(fail[g]), 0);
      chk($sformatf("%s_first%0d", nm, g), int'(ff[g]), 0);
    end
  endtask

  // Reference: mismatch set is simply the XOR of the two truth tables
  task automatic sweep(input string nm, input logic [7:0] t, input logic [7:0] c);
    int exp_err, exp_first;
    int got [3];
    int npulse [3];
    logic [7:0] diff;
    diff = t ^ c;
    exp_err = $countones(diff);
    exp_first = 0;
    for (int i = 7; i >= 0; i--) if (diff[i]) exp_first = i;
    for (int g = 0; g < 3; g++) begin
      got[g] = 0;
      npulse[g] = 0;
    end

    @(negedge clk);
    tt_ref = t;
    circ_tt = c;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    tt_ref = ~t ^ 8'h5A;
    chk({nm, "_v0"}, int'(vec[1]), 0);
    chk({nm, "_valid0"}, int'(vvalid[1]), 1);
    chk({nm, "_busy"}, int'(busy[2]), 1);
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < 8) chk($sformatf("%s_v%0d", nm, k), int'(vec[1]), k);
      if (k == 8) chk({nm, "_drain_valid"}, int'(vvalid[1]), 0);
      start = (k == 3);
      for (int g = 0; g < 3; g++) if (done[g]) begin
        npulse[g]++;
        if (got[g] == 0) got[g] = k;
      end
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_lat%0d_done_at", nm, lat_of[g]), got[g], 8 + lat_of[g] + 1);
      chk($sformatf("%s_lat%0d_pulses", nm, lat_of[g]), npulse[g], 1);
      chk($sformatf("%s_lat%0d_pass", nm, lat_of[g]), int'(pass[g]), int'(exp_err == 0));
      chk($sformatf("%s_lat%0d_err", nm, lat_of[g]), int'(errc[g]), exp_err);
      chk($sformatf("%s_lat%0d_fail", nm, lat_of[g]), int'(fail[g]), int'(exp_err != 0));
      chk($sformatf("%s_lat%0d_busy", nm, lat_of[g]), int'(busy[g]), 0);
      if (exp_err != 0)
        chk($sformatf("%s_lat%0d_first", nm, lat_of[g]), int'(ff[g]), exp_first);
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] tt;
    logic [7:0] circ;
  } vec_t;

  vec_t tbl [$];

  initial begin
    logic [7:0] mux_f, cons_f, xor_f;
    logic x, y, z;
    bit hit;
    int ndone;

    for (int i = 0; i < 8; i++) begin
      x = i[2];
      y = i[1];
      z = i[0];
      mux_f[i]  = (x & y) | (~x & z);
      cons_f[i] = (x & y) | (~x & z) | (y & z);
      xor_f[i]  = x ^ y ^ z;
    end
    tbl.push_back('{"mux", 8'hCA, mux_f});
    tbl.push_back('{"consensus", 8'hCA, cons_f});
    tbl.push_back('{"stuck0", 8'hCA, 8'h00});
    tbl.push_back('{"xor", 8'hCA, xor_f});
    tbl.push_back('{"allfail", 8'h00, 8'hFF});
    for (int r = 0; r < 6; r++)
      tbl.push_back('{$sformatf("rand%0d", r), 8'($urandom), 8'($urandom)});

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    foreach (tbl[i]) sweep(tbl[i].name, tbl[i].tt, tbl[i].circ);

    // Abort: start again while busy, then reset while vec_out=4
    @(negedge clk);
    tt_ref = 8'hCA;
    circ_tt = 8'h00;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (vec[1] == 3'd2) start = 1'b1;
      else start = 1'b0;
      if (vvalid[1] && vec[1] == 3'd4) hit = 1'b1;
      else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("abort_reached_vec4", int'(hit), 1);
    chk("abort_err_before_rst", int'(errc[1]), 1);
    chk("abort_fail_before_rst", int'(fail[1]), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("abort");
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < 3; g++) if (done[g] || busy[g]) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_err_after", int'(errc[2]), 0);

    sweep("post_abort", 8'hCA, mux_f);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
